// File: rtl/seq_divider_if.sv
// Start/done handshake and result bus of the sequential divider.
// signed_mode exists only when DIV_SIGNED_EN is defined.
interface seq_divider_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 7
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividendin;
  logic [DIVISOR_W-1:0]  divisorin;
`ifdef DIV_SIGNED_EN
  logic                  signed_mode;
`endif
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

`ifdef DIV_SIGNED_EN
  modport master (
    output start, dividendin, divisorin, signed_mode,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividendin, divisorin, signed_mode,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividendin, divisorin,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividendin, divisorin,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands via signed_mode.
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 7
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam int PW    = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]         p_q, p_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  d_q, d_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic                  nq_q, nq_d;
  logic                  nr_q, nr_d;

  logic [PW-1:0]         p_sh, t, p_step;
  logic [DIVIDEND_W-1:0] q_step, q_fin, a_mag;
  logic [DIVISOR_W-1:0]  r_fin, b_mag;
  logic                  t_ge, a_neg, b_neg;

  // P < D always holds, so the MSB of P-D at PW bits is a true sign
  always_comb begin
    p_sh   = {p_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
    t      = p_sh - {1'b0, d_q};
    t_ge   = ~t[PW-1];
    p_step = t_ge ? t : p_sh;
    q_step = {q_q[DIVIDEND_W-2:0], t_ge};
  end

  always_comb begin
`ifdef DIV_SIGNED_EN
    a_neg = bus.signed_mode & bus.dividendin[DIVIDEND_W-1];
    b_neg = bus.signed_mode & bus.divisorin[DIVISOR_W-1];
    a_mag = a_neg ? -bus.dividendin : bus.dividendin;
    b_mag = b_neg ? -bus.divisorin : bus.divisorin;
    q_fin = nq_q ? -q_step : q_step;
    r_fin = nr_q ? -p_step[DIVISOR_W-1:0]
                 : p_step[DIVISOR_W-1:0];
`else
    a_neg = 1'b0;
    b_neg = 1'b0;
    a_mag = bus.dividendin;
    b_mag = bus.divisorin;
    q_fin = q_step;
    r_fin = p_step[DIVISOR_W-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (bus.divisorin == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            q_d     = a_mag;
            d_d     = b_mag;
            p_d     = '0;
            cnt_d   = CNT_W'(DIVIDEND_W);
            nq_d    = a_neg ^ b_neg;
            nr_d    = a_neg;
          end
        end
      end
      S_RUN: begin
        p_d   = p_step;
        q_d   = q_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          quot_d  = q_fin;
          rem_d   = r_fin;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider results, latency and handshake.
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  seq_divider_if #(.DIVIDEND_W(8), .DIVISOR_W(7)) bus ();

  seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(7)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] b,
                       input logic sm);
    bus.start      = 1'b1;
    bus.dividendin = a;
    bus.divisorin  = b;
`ifdef DIV_SIGNED_EN
    bus.signed_mode = sm;
`else
    if (sm) $display("note: signed vector in unsigned build");
`endif
  endtask

  // Called just after a clock edge; start is seen on the next edge
  task automatic run_op(input string tag, input logic [7:0] a,
                        input logic [6:0] b, input logic sm,
                        input logic [7:0] eq, input logic [6:0] er,
                        input logic edbz, input int pulse_at);
    int cyc;
    int bcnt;
    drive(a, b, sm);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (!bus.done && cyc < 20) begin
      bcnt += int'(bus.busy);
      if (pulse_at != 0 && cyc == pulse_at)
        drive(8'd9, 7'd2, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
    end
    chk({tag, ".lat"}, cyc, edbz ? 0 : 8);
    chk({tag, ".busy"}, bcnt, edbz ? 0 : 8);
    chk({tag, ".q"}, bus.quotient, eq);
    chk({tag, ".r"}, bus.remainder, er);
    chk({tag, ".dbz"}, bus.div_by_zero, edbz);
  endtask

  initial begin
    logic [7:0] a, eq;
    logic [6:0] b, er;
    logic       sm, edbz;
    int         sa, sb, seen;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.dividendin = '0;
    bus.divisorin  = '0;
`ifdef DIV_SIGNED_EN
    bus.signed_mode = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.q", bus.quotient, 0);
    chk("rst.r", bus.remainder, 0);
    chk("rst.dbz", bus.div_by_zero, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("u200_7", 8'd200, 7'd7, 1'b0, 8'd28, 7'd4, 1'b0, 0);
    @(posedge clk); #1;
    chk("pulse1", bus.done, 0);
    chk("hold.q", bus.quotient, 28);
    chk("hold.r", bus.remainder, 4);

    run_op("u5_9", 8'd5, 7'd9, 1'b0, 8'd0, 7'd5, 1'b0, 0);
    run_op("u255_1", 8'd255, 7'd1, 1'b0, 8'd255, 7'd0, 1'b0, 0);
    run_op("u255_127", 8'd255, 7'd127, 1'b0, 8'd2, 7'd1, 1'b0, 0);
    run_op("u10_0", 8'd10, 7'd0, 1'b0, 8'hFF, 7'd0, 1'b1, 0);
    run_op("u12_3", 8'd12, 7'd3, 1'b0, 8'd4, 7'd0, 1'b0, 0);

    @(posedge clk); #1;
    run_op("busy_ign", 8'd200, 7'd7, 1'b0, 8'd28, 7'd4, 1'b0, 3);
    run_op("b2b_9_2", 8'd9, 7'd2, 1'b0, 8'd4, 7'd1, 1'b0, 0);

    @(posedge clk); #1;
    drive(8'd200, 7'd7, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mrst.q", bus.quotient, 0);
    chk("mrst.r", bus.remainder, 0);
    chk("mrst.busy", bus.busy, 0);
    chk("mrst.done", bus.done, 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      seen |= int'(bus.done) | int'(bus.busy);
    end
    reset = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen |= int'(bus.done) | int'(bus.busy);
    end
    chk("mrst.quiet", seen, 0);
    run_op("post_rst", 8'd100, 7'd7, 1'b0, 8'd14, 7'd2, 1'b0, 0);

`ifdef DIV_SIGNED_EN
    run_op("s-100_7", 8'h9C, 7'd7, 1'b1, 8'hF2, 7'h7E, 1'b0, 0);
    run_op("s-128_-1", 8'h80, 7'h7F, 1'b1, 8'h80, 7'd0, 1'b0, 0);
    run_op("s100_-7", 8'd100, 7'h79, 1'b1, 8'hF2, 7'd2, 1'b0, 0);
    run_op("s10_0", 8'd10, 7'd0, 1'b1, 8'hFF, 7'd0, 1'b1, 0);
`endif

    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom);
      b  = ($urandom % 16 == 0) ? 7'd0 : 7'($urandom);
`ifdef DIV_SIGNED_EN
      sm = 1'($urandom);
`else
      sm = 1'b0;
`endif
      if (sm) begin
        sa = int'($signed(a));
        sb = int'($signed(b));
      end else begin
        sa = int'(a);
        sb = int'(b);
      end
      if (b == 7'd0) begin
        eq   = 8'hFF;
        er   = 7'd0;
        edbz = 1'b1;
      end else begin
        eq   = 8'(sa / sb);
        er   = 7'(sa % sb);
        edbz = 1'b0;
      end
      run_op("rnd", a, b, sm, eq, er, edbz, 0);
      if (!sm && b != 7'd0)
        chk("rnd.inv",
            (int'(bus.quotient) * int'(b) + int'(bus.remainder)
               == int'(a)) && (bus.remainder < b), 1);
      if ($urandom % 2 == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
